// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-serial program loader for instruction memory.
// Packs four stream bytes big-endian into each 32-bit word and writes
// consecutive lines starting at line 0, holding fetch off while active.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing 4-byte word
// that must equal the XOR of all written words.
module instr_mem_loader #(
  parameter int          DEPTH     = 101,
  parameter logic [31:0] BASE_ADDR = 32'h0004_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [15:0] i_word_count,
  input  logic        i_in_valid,
  input  logic [7:0]  i_in_byte,
  output logic        o_in_ready,
  output logic        o_mem_we,
  output logic [31:0] o_mem_line,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic        o_fetch_hold,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RECV  = 3'd1,
    S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK = 3'd3,
`endif
    S_DONE  = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_in_ready;
  logic        w_mem_we;
  logic        w_accept;
  logic        w_reject;
  logic        w_hs;
  logic        w_last_byte;
  logic        w_bad_count;
  logic [31:0] w_word;
  logic [15:0] w_line_inc;

  logic [15:0] r_count;
  logic [15:0] r_line;
  logic [1:0]  r_bidx;
  logic [23:0] r_shift;
  logic [31:0] r_mem_line;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_error;
  logic        r_rej_done;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_xor;
`endif

  assign w_bad_count = (i_word_count == 16'd0) || ({16'd0, i_word_count} > 32'(DEPTH));
  assign w_hs        = w_in_ready && i_in_valid;
  assign w_last_byte = w_hs && (r_bidx == 2'd3);
  assign w_word      = {r_shift, i_in_byte};
  assign w_line_inc  = r_line + 16'd1;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and per-state strobes
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_mem_we   = 1'b0;
    w_accept   = 1'b0;
    w_reject   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          if (w_bad_count) begin
            w_reject = 1'b1;
          end else begin
            w_accept = 1'b1;
            w_next   = S_RECV;
          end
        end
      end
      S_RECV: begin
        w_in_ready = 1'b1;
        if (i_in_valid && (r_bidx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_mem_we = 1'b1;
        if (w_line_inc == r_count) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_in_ready = 1'b1;
        if (i_in_valid && (r_bidx == 2'd3)) w_next = S_DONE;
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Session counters, byte packing, write-port registers and error flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count     <= '0;
      r_line      <= '0;
      r_bidx      <= '0;
      r_shift     <= '0;
      r_mem_line  <= '0;
      r_mem_addr  <= BASE_ADDR;
      r_mem_wdata <= '0;
      r_error     <= 1'b0;
      r_rej_done  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_rej_done <= w_reject;
      if (w_reject) r_error <= 1'b1;
      if (w_accept) begin
        r_error <= 1'b0;
        r_count <= i_word_count;
        r_line  <= '0;
        r_bidx  <= '0;
`ifdef LOADER_CHECKSUM_EN
        r_xor   <= '0;
`endif
      end
      if (w_hs) begin
        r_bidx  <= r_bidx + 2'd1;
        r_shift <= {r_shift[15:0], i_in_byte};
      end
      // The write-port registers only change when a full word is captured,
      // so they hold their values through every non-write cycle.
      if (w_last_byte && (r_state == S_RECV)) begin
        r_mem_wdata <= w_word;
        r_mem_line  <= {16'd0, r_line};
        r_mem_addr  <= BASE_ADDR + {14'd0, r_line, 2'b00};
      end
`ifdef LOADER_CHECKSUM_EN
      if (w_last_byte && (r_state == S_CHECK) && (w_word != r_xor)) r_error <= 1'b1;
`endif
      if (w_mem_we) begin
        r_line <= w_line_inc;
`ifdef LOADER_CHECKSUM_EN
        r_xor  <= r_xor ^ r_mem_wdata;
`endif
      end
    end
  end

  assign o_in_ready   = w_in_ready;
  assign o_mem_we     = w_mem_we;
  assign o_mem_line   = r_mem_line;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = (r_state != S_IDLE);
  assign o_fetch_hold = (r_state != S_IDLE);
  assign o_done       = (r_state == S_DONE) || r_rej_done;
  assign o_error      = r_error;

endmodule
